// File: rtl/macro_select_ctrl.sv
// Wishbone-programmable enable controller for the user-project test macros.
// Drives one-hot (or zero) io_active enables with a break-before-make sequence
// so two macros never drive the shared outputs together. An LA override can
// force the target pattern without a bus master.
module macro_select_ctrl #(
  parameter int unsigned NUM_MACROS  = 4,
  parameter int unsigned DEAD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic                  la_ovr_i,
  input  logic [NUM_MACROS-1:0] la_sel_i,
  output logic [NUM_MACROS-1:0] io_active_o,
  output logic                  switch_busy_o
);

  // Word offsets within the register block
  localparam logic [5:0] OffSel    = 6'h00;
  localparam logic [5:0] OffStatus = 6'h01;
  localparam logic [5:0] OffClr    = 6'h02;

  // BREAK holds for DEAD_CYCLES cycles: the load value plus the cycle at zero
  localparam logic [7:0] DeadLoad = 8'(DEAD_CYCLES - 1);
  localparam logic [NUM_MACROS-1:0] OneM = NUM_MACROS'(1);

  typedef enum logic [1:0] {
    StStable,
    StBreak,
    StSettle
  } state_e;

  // True when v has at most one bit set
  function automatic logic onehot0(input logic [NUM_MACROS-1:0] v);
    return (v & (v - OneM)) == '0;
  endfunction

  // Bus handshake state
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;

  // Register file
  logic [NUM_MACROS-1:0] sel_q, sel_d;
  logic                  err_q, err_d;
  logic [7:0]            swcnt_q, swcnt_d;

  // Switch sequencer
  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NUM_MACROS-1:0] tgt_q, tgt_d;
  logic [NUM_MACROS-1:0] io_q, io_d;

  // Decode
  logic                  req;
  logic                  hit;
  logic                  acc;
  logic                  wr_lane0;
  logic                  sel_wr;
  logic                  clr_wr;
  logic [5:0]            off;
  logic [NUM_MACROS-1:0] wdat;
  logic                  wdat_ok;
  logic                  busy;
  logic [NUM_MACROS-1:0] target;
  logic [31:0]           status_word;
  logic [31:0]           sel_word;
  logic                  unused_bits;

  // Ack is registered, so a held strobe is not re-sampled during its own ack cycle
  assign req      = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign acc      = req & hit;
  assign off      = wbs_adr_i[7:2];
  assign wr_lane0 = acc & wbs_we_i & wbs_sel_i[0];
  assign sel_wr   = wr_lane0 & (off == OffSel);
  assign clr_wr   = wr_lane0 & (off == OffClr);
  // Only the pattern field is judged; upper data bits are don't-care
  assign wdat     = wbs_dat_i[NUM_MACROS-1:0];
  assign wdat_ok  = onehot0(wdat);

  assign busy     = (state_q != StStable);

  // Lanes 1..3 and byte-offset bits have no function here
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i, wbs_adr_i[1:0]};

  // Effective target: an invalid LA pattern parks everything off
  always_comb begin
    target = sel_q;
    if (la_ovr_i) begin
      target = onehot0(la_sel_i) ? la_sel_i : '0;
    end
  end

  // Readable words, zero-extended
  always_comb begin
    status_word                   = '0;
    status_word[NUM_MACROS-1:0]   = io_q;
    status_word[8]                = busy;
    status_word[9]                = err_q;
    status_word[23:16]            = swcnt_q;
    sel_word                      = '0;
    sel_word[NUM_MACROS-1:0]      = sel_q;
  end

  // Ack and read data for the accepted request; data is zero outside reads
  always_comb begin
    ack_d = acc;
    dat_d = '0;
    if (acc && !wbs_we_i) begin
      case (off)
        OffSel:    dat_d = sel_word;
        OffStatus: dat_d = status_word;
        default:   dat_d = '0;
      endcase
    end
  end

  // Bus handshake registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  // Register-file next state: SEL writes, sticky ERR, saturating SWCNT
  always_comb begin
    sel_d   = sel_q;
    err_d   = err_q;
    swcnt_d = swcnt_q;

    if (sel_wr) begin
      if (wdat_ok) begin
        sel_d = wdat;
      end else begin
        err_d = 1'b1;
      end
    end

    // Count completed switches to a live macro
    if ((state_q == StSettle) && (tgt_q != '0) && (swcnt_q != 8'hFF)) begin
      swcnt_d = swcnt_q + 8'd1;
    end

    // Software clear takes priority over a same-cycle increment
    if (clr_wr) begin
      if (wbs_dat_i[0]) begin
        err_d = 1'b0;
      end
      if (wbs_dat_i[1]) begin
        swcnt_d = '0;
      end
    end
  end

  // Register-file state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      sel_q   <= '0;
      err_q   <= 1'b0;
      swcnt_q <= '0;
    end else begin
      sel_q   <= sel_d;
      err_q   <= err_d;
      swcnt_q <= swcnt_d;
    end
  end

  // Switch sequencer next state: every change drops all enables for the dead
  // time before the new pattern is applied
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    io_d    = io_q;

    case (state_q)
      StStable: begin
        if (target != io_q) begin
          tgt_d   = target;
          io_d    = '0;
          cnt_d   = DeadLoad;
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          io_d    = tgt_q;
          state_d = StSettle;
        end
      end
      StSettle: begin
        // Target changes seen during the switch are picked up from here
        state_d = StStable;
      end
      default: begin
        io_d    = '0;
        state_d = StStable;
      end
    endcase
  end

  // Switch sequencer state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StStable;
      cnt_q   <= '0;
      tgt_q   <= '0;
      io_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      io_q    <= io_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign io_active_o   = io_q;
  assign switch_busy_o = busy;

`ifndef SYNTHESIS
  // Enables stay mutually exclusive; ack never holds two cycles
  a_io_onehot0: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    onehot0(io_q));
  a_ack_pulse: assert property (@(posedge wb_clk_i) disable iff (!wb_rst_n_i)
    ack_q |=> !ack_q);
`endif

endmodule

// File: tb/tb_macro_select_ctrl.sv
// Self-checking bench for macro_select_ctrl: directed scenarios plus a randomized
// sequence checked against a register-level model of the controller.
module tb_macro_select_ctrl;

  localparam int unsigned NM   = 4;
  localparam int unsigned DEAD = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk;
  logic          rst_n;
  logic          stb;
  logic          cyc;
  logic          we;
  logic [3:0]    sel;
  logic [31:0]   wdat;
  logic [31:0]   adr;
  logic          ack;
  logic [31:0]   rdat;
  logic          la_ovr;
  logic [NM-1:0] la_sel;
  logic [NM-1:0] io;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model of the architectural state
  logic [NM-1:0] m_sel;
  logic          m_err;
  int unsigned   m_swcnt;
  logic [NM-1:0] m_io;
  logic          m_ovr;
  logic [NM-1:0] m_la;

  logic [NM-1:0] rec[$];

  macro_select_ctrl #(
    .NUM_MACROS (NM),
    .DEAD_CYCLES(DEAD),
    .BASE_ADDR  (BASE)
  ) u_dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (wdat),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (rdat),
    .la_ovr_i     (la_ovr),
    .la_sel_i     (la_sel),
    .io_active_o  (io),
    .switch_busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

  function automatic logic onehot0(input logic [NM-1:0] v);
    return $countones(v) <= 1;
  endfunction

  function automatic logic [31:0] status_exp(input logic [NM-1:0] io_v, input logic b,
                                             input logic e, input int unsigned cnt);
    return {8'h00, 8'(cnt), 6'h00, e, b, 4'h0, io_v};
  endfunction

  function automatic logic [NM-1:0] model_target();
    if (m_ovr) return onehot0(m_la) ? m_la : '0;
    return m_sel;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One bus transfer; reports whether and when it was acked (lat=1 means next cycle)
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic acked, output logic [31:0] rd,
                         output int lat);
    @(posedge clk);
    #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; rd = '0; lat = 0;
    for (int i = 1; i <= 4 && !acked; i++) begin
      step();
      if (ack) begin
        acked = 1'b1;
        rd    = rdat;
        lat   = i;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; wdat = '0;
  endtask

  task automatic test_reset();
    logic ok; logic [31:0] d; int lat;
    rst_n = 1'b0;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; wdat = 32'h1; sel = 4'hF;
    la_ovr = 1'b1; la_sel = 4'h2;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({ack, rdat, io, busy} !== '0) begin
        bad++;
        $display("FAIL reset_outputs got=%0h/%0h/%0h/%0h want=0", ack, rdat, io, busy);
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; wdat = '0;
    la_ovr = 1'b0; la_sel = '0;
    step();
    rst_n = 1'b1;
    idle(2);
    m_sel = '0; m_err = 1'b0; m_swcnt = 0; m_io = '0; m_ovr = 1'b0; m_la = '0;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (!ok || lat != 1) begin
      bad++; $display("FAIL reset_read_ack got=%0d/%0d want=1/1", ok, lat);
    end
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL reset_status got=%08h want=00000000", d);
    end
  endtask

  task automatic test_sel_write();
    logic ok; logic [31:0] d; int lat;
    logic [NM-1:0] e_io; logic e_busy;
    wb_xfer(1'b1, BASE, 32'h1, 4'h1, ok, d, lat);
    total++;
    if (!ok || lat != 1) begin
      bad++; $display("FAIL sel_write_ack got=%0d/%0d want=1/1", ok, lat);
    end
    // Now in cycle N+1
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) step();
      e_io   = (k >= 2 + int'(DEAD)) ? 4'h1 : 4'h0;
      e_busy = (k >= 2 && k <= 2 + int'(DEAD));
      total++;
      if (io !== e_io || busy !== e_busy) begin
        bad++;
        $display("FAIL sel_write_seq N+%0d got=%0h/%0b want=%0h/%0b", k, io, busy, e_io, e_busy);
      end
    end
    m_sel = 4'h1; m_io = 4'h1; m_swcnt = 1;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (!ok || d !== 32'h0001_0001) begin
      bad++; $display("FAIL sel_write_status got=%0d/%08h want=1/00010001", ok, d);
    end
  endtask

  task automatic test_switch();
    logic ok; logic [31:0] d; int lat; int zeros; logic done;
    wb_xfer(1'b1, BASE, 32'h4, 4'h1, ok, d, lat);
    total++;
    if (!ok) begin
      bad++; $display("FAIL switch_ack got=0 want=1");
    end
    zeros = 0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      total++;
      if (!onehot0(io) || (io != 4'h0 && io != 4'h1 && io != 4'h4)) begin
        bad++; $display("FAIL switch_onehot got=%0h want=0/1/4", io);
      end
      if (io == 4'h0) zeros++;
      if (io == 4'h4) done = 1'b1;
      else step();
    end
    total++;
    if (!done || zeros != int'(DEAD)) begin
      bad++; $display("FAIL switch_dead got=%0d/%0d want=1/%0d", done, zeros, DEAD);
    end
    m_sel = 4'h4; m_io = 4'h4; m_swcnt = 2;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== status_exp(m_io, 1'b0, m_err, m_swcnt)) begin
      bad++; $display("FAIL switch_status got=%08h want=%08h", d,
                      status_exp(m_io, 1'b0, m_err, m_swcnt));
    end
  endtask

  task automatic test_err();
    logic ok; logic [31:0] d; int lat;
    wb_xfer(1'b1, BASE, 32'h3, 4'h1, ok, d, lat);
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (io !== 4'h4 || busy !== 1'b0) begin
        bad++; $display("FAIL err_io_hold got=%0h/%0b want=4/0", io, busy);
      end
    end
    m_err = 1'b1;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== 32'h0002_0204) begin
      bad++; $display("FAIL err_status_set got=%08h want=00020204", d);
    end
    wb_xfer(1'b1, BASE + 32'h8, 32'h1, 4'h1, ok, d, lat);
    m_err = 1'b0;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== 32'h0002_0004) begin
      bad++; $display("FAIL err_status_clr got=%08h want=00020004", d);
    end
    wb_xfer(1'b0, BASE, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== 32'h4) begin
      bad++; $display("FAIL err_sel_kept got=%08h want=00000004", d);
    end
  endtask

  // Drive an LA change in cycle M and check io over M..M+DEAD+1
  task automatic la_change(input logic ovr, input logic [NM-1:0] s, input logic [NM-1:0] from,
                           input logic [NM-1:0] to, input string nm);
    logic [NM-1:0] e;
    la_ovr = ovr; la_sel = s;
    for (int k = 0; k <= int'(DEAD) + 1; k++) begin
      if (k > 0) step();
      e = (k == 0) ? from : (k <= int'(DEAD)) ? 4'h0 : to;
      total++;
      if (io !== e) begin
        bad++; $display("FAIL %s M+%0d got=%0h want=%0h", nm, k, io, e);
      end
    end
    idle(3);
  endtask

  task automatic test_la();
    logic ok; logic [31:0] d; int lat;
    step();
    la_change(1'b1, 4'h8, 4'h4, 4'h8, "la_to_8");
    la_change(1'b1, 4'h6, 4'h8, 4'h0, "la_invalid");
    la_change(1'b0, 4'h6, 4'h0, 4'h4, "la_release");
    la_sel = '0;
    m_swcnt = 4;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== status_exp(4'h4, 1'b0, 1'b0, 4)) begin
      bad++; $display("FAIL la_status got=%08h want=%08h", d, status_exp(4'h4, 1'b0, 1'b0, 4));
    end
  endtask

  task automatic test_back_to_back();
    logic ok, ok2; logic [31:0] d; int lat;
    logic [NM-1:0] vals[$]; int lens[$];
    logic [NM-1:0] exp_vals [5];
    exp_vals = '{4'h4, 4'h0, 4'h2, 4'h0, 4'h4};
    rec.delete();
    wb_xfer(1'b1, BASE, 32'h2, 4'h1, ok, d, lat);
    fork
      wb_xfer(1'b1, BASE, 32'h4, 4'h1, ok2, d, lat);
      for (int i = 0; i < 18; i++) begin
        rec.push_back(io);
        step();
      end
    join
    total++;
    if (!ok || !ok2) begin
      bad++; $display("FAIL b2b_acks got=%0d/%0d want=1/1", ok, ok2);
    end
    foreach (rec[i]) begin
      if (vals.size() == 0 || vals[vals.size()-1] != rec[i]) begin
        vals.push_back(rec[i]); lens.push_back(1);
      end else begin
        lens[lens.size()-1] = lens[lens.size()-1] + 1;
      end
    end
    total++;
    if (vals.size() != 5) begin
      bad++; $display("FAIL b2b_runs got=%0d want=5", vals.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (vals[i] !== exp_vals[i]) begin
          bad++; $display("FAIL b2b_value[%0d] got=%0h want=%0h", i, vals[i], exp_vals[i]);
        end
      end
      total++;
      if (lens[1] != int'(DEAD) || lens[2] != 2 || lens[3] != int'(DEAD)) begin
        bad++;
        $display("FAIL b2b_lengths got=%0d/%0d/%0d want=%0d/2/%0d", lens[1], lens[2], lens[3],
                 DEAD, DEAD);
      end
    end
    m_sel = 4'h4; m_io = 4'h4; m_swcnt = 6;
  endtask

  task automatic test_bus_edges();
    logic ok; logic [31:0] d; int lat; logic e_ack;
    // Held strobe: acks alternate, never two in a row
    step();
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h4; sel = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      step();
      e_ack = (k % 2) == 1;
      total++;
      if (ack !== e_ack) begin
        bad++; $display("FAIL held_ack N+%0d got=%0b want=%0b", k, ack, e_ack);
      end
      if (e_ack) begin
        total++;
        if (rdat !== status_exp(4'h4, 1'b0, 1'b0, 6)) begin
          bad++; $display("FAIL held_data got=%08h want=%08h", rdat,
                          status_exp(4'h4, 1'b0, 1'b0, 6));
        end
      end
    end
    stb = 1'b0; cyc = 1'b0; sel = 4'h0;
    wb_xfer(1'b0, BASE + 32'h100, '0, 4'hF, ok, d, lat);
    total++;
    if (ok !== 1'b0) begin
      bad++; $display("FAIL outside_no_ack got=%0b want=0", ok);
    end
    wb_xfer(1'b1, BASE + 32'h10, 32'h1, 4'hF, ok, d, lat);
    wb_xfer(1'b0, BASE + 32'hC, '0, 4'hF, ok, d, lat);
    total++;
    if (ok !== 1'b1 || d !== 32'h0) begin
      bad++; $display("FAIL unused_offset got=%0b/%08h want=1/00000000", ok, d);
    end
    wb_xfer(1'b0, BASE, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== 32'h4) begin
      bad++; $display("FAIL unused_write_sel got=%08h want=00000004", d);
    end
  endtask

  task automatic test_reset_mid_switch();
    logic ok; logic [31:0] d; int lat;
    wb_xfer(1'b1, BASE, 32'h1, 4'h1, ok, d, lat);
    idle(2);
    total++;
    if (busy !== 1'b1 || io !== 4'h0) begin
      bad++; $display("FAIL rst_pre_break got=%0b/%0h want=1/0", busy, io);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ack, rdat, io, busy} !== '0) begin
      bad++; $display("FAIL rst_break_outputs got=%0h/%0h/%0h/%0b want=0", ack, rdat, io, busy);
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (io !== 4'h0 || busy !== 1'b0) begin
        bad++; $display("FAIL rst_stable got=%0h/%0b want=0/0", io, busy);
      end
    end
    // Reset again while a macro is live in SETTLE
    wb_xfer(1'b1, BASE, 32'h2, 4'h1, ok, d, lat);
    idle(int'(DEAD) + 1);
    total++;
    if (io !== 4'h2 || busy !== 1'b1) begin
      bad++; $display("FAIL rst_pre_settle got=%0h/%0b want=2/1", io, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (io !== 4'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_settle_outputs got=%0h/%0b want=0/0", io, busy);
    end
    #3 rst_n = 1'b1;
    idle(3);
    m_sel = '0; m_err = 1'b0; m_swcnt = 0; m_io = '0;
    wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL rst_status got=%08h want=00000000", d);
    end
  endtask

  task automatic test_random();
    logic ok; logic [31:0] d; int lat;
    int op; logic [NM-1:0] v; logic lane; logic [NM-1:0] tgt;
    logic [NM-1:0] last_nz; int zrun;
    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 3));
      last_nz = io; zrun = 0;
      case (op)
        0: begin
          v = NM'($urandom_range(0, 15));
          lane = ($urandom_range(0, 3) != 0);
          wb_xfer(1'b1, BASE, {28'h0, v}, lane ? 4'h1 : 4'hE, ok, d, lat);
          if (lane) begin
            if (onehot0(v)) m_sel = v;
            else m_err = 1'b1;
          end
        end
        1: begin
          m_ovr = 1'($urandom_range(0, 1));
          m_la  = NM'($urandom_range(0, 15));
          step();
          la_ovr = m_ovr; la_sel = m_la;
        end
        2: begin
          v = NM'($urandom_range(0, 3));
          wb_xfer(1'b1, BASE + 32'h8, {28'h0, v}, 4'h1, ok, d, lat);
          if (v[0]) m_err = 1'b0;
          if (v[1]) m_swcnt = 0;
        end
        default: begin
          wb_xfer(1'b0, BASE, '0, 4'hF, ok, d, lat);
          total++;
          if (d !== {28'h0, m_sel}) begin
            bad++; $display("FAIL rand_sel_read got=%08h want=%08h", d, {28'h0, m_sel});
          end
        end
      endcase
      tgt = model_target();
      if (tgt != m_io) begin
        if (tgt != '0 && m_swcnt < 255) m_swcnt++;
        m_io = tgt;
      end
      for (int c = 0; c < 2 * int'(DEAD) + 8; c++) begin
        step();
        total++;
        if (!onehot0(io)) begin
          bad++; $display("FAIL rand_onehot got=%0h want=onehot0", io);
        end
        if (io == '0) begin
          zrun++;
        end else begin
          if (last_nz != '0 && io != last_nz) begin
            total++;
            if (zrun != int'(DEAD)) begin
              bad++; $display("FAIL rand_dead got=%0d want=%0d", zrun, DEAD);
            end
          end
          last_nz = io; zrun = 0;
        end
      end
      total++;
      if (io !== m_io || busy !== 1'b0) begin
        bad++; $display("FAIL rand_io it=%0d got=%0h/%0b want=%0h/0", it, io, busy, m_io);
      end
      wb_xfer(1'b0, BASE + 32'h4, '0, 4'hF, ok, d, lat);
      total++;
      if (d !== status_exp(m_io, 1'b0, m_err, m_swcnt)) begin
        bad++; $display("FAIL rand_status it=%0d got=%08h want=%08h", it, d,
                        status_exp(m_io, 1'b0, m_err, m_swcnt));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    wdat = '0; adr = '0; la_ovr = 1'b0; la_sel = '0;
    test_reset();
    test_sel_write();
    test_switch();
    test_err();
    test_la();
    test_back_to_back();
    test_bus_edges();
    test_reset_mid_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/macro_select_ctrl.md
# macro_select_ctrl

Wishbone-programmable enable controller for the test macros in `user_project_wrapper`. It sits upstream of the macros and drives their one-hot `io_active` enables. Macro switching uses a break-before-make sequence, so no two macros ever drive the shared io/Wishbone outputs at the same time. A logic-analyzer override lets the enable be forced without a bus master.

## Interface

Parameters:
- NUM_MACROS, 4, number of macro enables (1..8)
- DEAD_CYCLES, 4, cycles all enables are held low between macros (1..255)
- BASE_ADDR, 32'h3000_0000, register block base; decode on adr[31:8]

Ports:
- Clocking/reset (already decided): one clock, `wb_clk_i`; reset `wb_rst_n_i` is asynchronous and active-low.
- wb_clk_i  in  1  sole clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte lanes; only lane 0 is used
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- la_ovr_i  in  1  LA override enable
- la_sel_i  in  NUM_MACROS  LA-requested enable pattern
- io_active_o  out  NUM_MACROS  one-hot (or zero) macro enables
- switch_busy_o  out  1  high while a switch is in progress

## Operation

- Registers are word-aligned at offset adr[7:2]. A request is selected when adr[31:8]==BASE_ADDR[31:8].
  - 0x00 SEL (RW): bits[NUM_MACROS-1:0] hold the requested pattern. A write with wbs_sel_i[0]=1 updates SEL only if the data is zero or one-hot. Any other value is ignored and sets ERR.
  - 0x04 STATUS (RO): [7:0] io_active_o zero-extended; [8] busy; [9] ERR (sticky); [23:16] SWCNT.
  - 0x08 CLR (W1C): bit0 clears ERR; bit1 clears SWCNT.
  - Other offsets in the block read 0, ignore writes, and still ack. Requests outside the block get no ack.
- Effective target:
  - When la_ovr_i=1, the target is la_sel_i. If la_sel_i is not zero or one-hot, the target is 0.
  - When la_ovr_i=0, the target is SEL.
- FSM states: STABLE, BREAK, SETTLE.
  - STABLE: if target != io_active_o, latch the target into tgt_q, drive io_active_o to 0, load cnt to DEAD_CYCLES-1, and go to BREAK.
  - BREAK: io_active_o stays 0. While cnt != 0, decrement cnt. At cnt==0, set io_active_o to tgt_q and go to SETTLE.
  - SETTLE: stay one cycle, then go to STABLE. SWCNT increments here if tgt_q != 0, saturating at 255.
- switch_busy_o is 1 in BREAK and SETTLE.
- Target changes during BREAK or SETTLE do not alter tgt_q. They are evaluated on the next STABLE cycle.
- Every change, including zero to nonzero, passes through BREAK.
- Reset values: io_active_o=0, switch_busy_o=0, wbs_ack_o=0, wbs_dat_o=0, SEL=0, ERR=0, SWCNT=0, state STABLE.
- Asserting reset mid-switch zeroes all outputs immediately, asynchronously.

## Timing

- A request is sampled in cycle N (stb&cyc&!ack). The register update and ack/data appear in cycle N+1, and ack drops in N+2. Ack is never high two cycles in a row; a held strobe is re-acked at N+3.
- After a SEL write at N (SEL visible at N+1):
  - N+2 .. N+1+DEAD_CYCLES: BREAK, io_active_o=0.
  - N+2+DEAD_CYCLES: io_active_o = new value; state SETTLE.
  - N+3+DEAD_CYCLES: STABLE; busy low.
- A LA override change sampled at cycle M gives io_active_o=0 at M+1 and the new value at M+1+DEAD_CYCLES.
- Invariant: io_active_o never has more than one bit set. Between any two different nonzero values, it is 0 for exactly DEAD_CYCLES cycles.
- STATUS reads return the values registered at the ack cycle.

## Test plan

- Reset: hold wb_rst_n_i=0 with bus activity present. Required: all outputs 0. After release, a read of 0x04 returns 0x0000_0000.
- Write SEL=0x1 at N (DEAD_CYCLES=4). Required: ack at N+1; io_active_o=0 through N+5 and 0x1 at N+6; busy high N+2..N+6; STATUS returns 0x0001_0001.
- Switch 0x1 to 0x4. Required: io_active_o is 0 for exactly 4 cycles and never has two bits set; SWCNT=2.
- Write SEL=0x3. Required: io_active_o unchanged; STATUS bit9=1. Then write CLR=0x1. Required: bit9=0 and SEL unchanged.
- la_ovr_i=1, la_sel_i=0x8. Required: switch to 0x8 with dead time. Then la_sel_i=0x6. Required: io_active_o goes to 0. Then la_ovr_i=0. Required: return to the SEL value.
- Write SEL=0x2, then SEL=0x4 during BREAK. Required: io_active_o becomes 0x2, then goes through a second break to 0x4. Separately, pulse reset mid-BREAK. Required: all outputs 0 immediately and STABLE after release.
